// File: rtl/pcs_sync_rx_lanes_pkg.sv
// Shared definitions for the multi-lane 64b/66b block-lock tracker.
//   SYNC_DATA / SYNC_CTRL : the two legal sync header codes
//   lane_state_e          : per-lane lock FSM states
//   sync_head_ok()        : true for a legal (data or control) sync header
package pcs_sync_rx_lanes_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    LANE_UNLOCKED,
    LANE_LOCKED,
    LANE_SLIP_WAIT
  } lane_state_e;

  function automatic logic sync_head_ok(input logic [1:0] head);
    return (head == SYNC_DATA) || (head == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/pcs_sync_rx_lanes_if.sv
// Bus between the RX gearbox and the block-lock tracker.
//   signal_ok_i : PMA signal ok per lane
//   valid_i     : head_i lane slice valid this cycle
//   head_i      : sync headers, lane l at [l*HEAD_W +: HEAD_W]
//   slip_v_o    : 1-cycle slip request per lane (back to gearbox)
//   lock_v_o    : per-lane block lock
//   lock_all_o  : all lanes locked
// master = gearbox / lock consumer side, slave = tracker.
interface pcs_sync_rx_lanes_if #(
  parameter int unsigned LANE_CNT = 4,
  parameter int unsigned HEAD_W   = 2
);
  logic [LANE_CNT-1:0]        signal_ok_i;
  logic [LANE_CNT-1:0]        valid_i;
  logic [LANE_CNT*HEAD_W-1:0] head_i;
  logic [LANE_CNT-1:0]        slip_v_o;
  logic [LANE_CNT-1:0]        lock_v_o;
  logic                       lock_all_o;

  modport master (
    output signal_ok_i, valid_i, head_i,
    input  slip_v_o, lock_v_o, lock_all_o
  );

  modport slave (
    input  signal_ok_i, valid_i, head_i,
    output slip_v_o, lock_v_o, lock_all_o
  );
endinterface

// File: rtl/pcs_sync_rx_lanes_lane.sv
// Single-lane block-lock FSM with window counters and slip-wait timer.
//   clk, reset   : core clock, async active-high reset
//   signal_ok_i  : PMA signal ok; low forces the lane unlocked (no slip)
//   valid_i      : head_i valid this cycle
//   head_i       : 2-bit sync header
//   slip_v_o     : registered 1-cycle slip request
//   lock_v_o     : registered block lock
//   lock_nxt_o   : value lock_v_o takes at the next edge (feeds the
//                  aggregate lock register so it aligns with lock_v_o)
// Inputs are captured in a stage register first; the FSM acts on the
// staged values, so a head sampled at edge N shows on outputs after N+1.
module pcs_sync_rx_lanes_lane
  import pcs_sync_rx_lanes_pkg::*;
#(
  parameter int unsigned LOCK_CNT    = 64,
  parameter int unsigned INVALID_MAX = 16,
  parameter int unsigned SLIP_WAIT   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       signal_ok_i,
  input  logic       valid_i,
  input  logic [1:0] head_i,
  output logic       slip_v_o,
  output logic       lock_v_o,
  output logic       lock_nxt_o
);

  localparam int unsigned CNT_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [CNT_W-1:0]  LOCK_CNT_V    = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]  INVALID_MAX_V = CNT_W'(INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LOAD     = WAIT_W'(SLIP_WAIT - 1);

  logic              ok_q, vld_q;
  logic [1:0]        head_q;
  lane_state_e       state_q, state_d;
  logic [CNT_W-1:0]  sh_q, sh_d, inv_q, inv_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              slip_q, slip_d, lock_q, lock_d;

  logic [CNT_W-1:0]  sh_inc, inv_inc;
  logic              head_good;

  assign sh_inc    = sh_q + CNT_W'(1);
  assign inv_inc   = inv_q + CNT_W'(1);
  assign head_good = sync_head_ok(head_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ok_q    <= 1'b0;
      vld_q   <= 1'b0;
      head_q  <= '0;
      state_q <= LANE_UNLOCKED;
      sh_q    <= '0;
      inv_q   <= '0;
      wait_q  <= '0;
      slip_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      ok_q    <= signal_ok_i;
      vld_q   <= valid_i;
      head_q  <= head_i;
      state_q <= state_d;
      sh_q    <= sh_d;
      inv_q   <= inv_d;
      wait_q  <= wait_d;
      slip_q  <= slip_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    inv_d   = inv_q;
    wait_d  = wait_q;
    if (!ok_q) begin
      state_d = LANE_UNLOCKED;
      sh_d    = '0;
      inv_d   = '0;
      wait_d  = '0;
    end else begin
      unique case (state_q)
        LANE_UNLOCKED: begin
          if (vld_q) begin
            if (!head_good) begin
              state_d = LANE_SLIP_WAIT;
              sh_d    = '0;
              inv_d   = '0;
              wait_d  = WAIT_LOAD;
            end else if (sh_inc == LOCK_CNT_V) begin
              state_d = LANE_LOCKED;
              sh_d    = '0;
              inv_d   = '0;
            end else begin
              sh_d = sh_inc;
            end
          end
        end
        LANE_LOCKED: begin
          if (vld_q) begin
            // invalid-limit check wins over a window that ends on the same head
            if (!head_good && (inv_inc == INVALID_MAX_V)) begin
              state_d = LANE_SLIP_WAIT;
              sh_d    = '0;
              inv_d   = '0;
              wait_d  = WAIT_LOAD;
            end else if (sh_inc == LOCK_CNT_V) begin
              sh_d  = '0;
              inv_d = '0;
            end else begin
              sh_d  = sh_inc;
              inv_d = head_good ? inv_q : inv_inc;
            end
          end
        end
        LANE_SLIP_WAIT: begin
          if (wait_q == '0) begin
            state_d = LANE_UNLOCKED;
            sh_d    = '0;
            inv_d   = '0;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        default: begin
          state_d = LANE_UNLOCKED;
          sh_d    = '0;
          inv_d   = '0;
          wait_d  = '0;
        end
      endcase
    end
  end

  // A slip is issued exactly on entry to SLIP_WAIT; signal loss never enters it.
  always_comb begin
    slip_d = (state_q != LANE_SLIP_WAIT) && (state_d == LANE_SLIP_WAIT);
    lock_d = (state_d == LANE_LOCKED);
  end

  assign slip_v_o   = slip_q;
  assign lock_v_o   = lock_q;
  assign lock_nxt_o = lock_d;

endmodule

// File: rtl/pcs_sync_rx_lanes.sv
// Multi-lane 64b/66b block-lock tracker for the RX PCS.
//   clk, reset : core clock, async active-high reset
//   bus        : slave side of pcs_sync_rx_lanes_if (heads/valid/signal ok
//                in from the gearbox; slip requests and lock status out)
// One independent lane FSM per lane; lock_all_o is registered from the
// lanes' next-cycle lock values so it changes together with lock_v_o.
module pcs_sync_rx_lanes
  import pcs_sync_rx_lanes_pkg::*;
#(
  parameter int unsigned LANE_CNT    = 4,
  parameter int unsigned HEAD_W      = 2,
  parameter int unsigned LOCK_CNT    = 64,
  parameter int unsigned INVALID_MAX = 16,
  parameter int unsigned SLIP_WAIT   = 4
) (
  input logic               clk,
  input logic               reset,
  pcs_sync_rx_lanes_if.slave bus
);

  if (HEAD_W != 2) begin : g_bad_head_w
    $error("pcs_sync_rx_lanes: HEAD_W must be 2");
  end
  if ((INVALID_MAX < 1) || (INVALID_MAX > LOCK_CNT)) begin : g_bad_invalid_max
    $error("pcs_sync_rx_lanes: INVALID_MAX must be in 1..LOCK_CNT");
  end
  if (SLIP_WAIT < 1) begin : g_bad_slip_wait
    $error("pcs_sync_rx_lanes: SLIP_WAIT must be at least 1");
  end

  logic [LANE_CNT-1:0] slip_v, lock_v, lock_nxt;
  logic                lock_all_q;

  for (genvar l = 0; l < LANE_CNT; l++) begin : g_lane
    pcs_sync_rx_lanes_lane #(
      .LOCK_CNT    (LOCK_CNT),
      .INVALID_MAX (INVALID_MAX),
      .SLIP_WAIT   (SLIP_WAIT)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .signal_ok_i (bus.signal_ok_i[l]),
      .valid_i     (bus.valid_i[l]),
      .head_i      (bus.head_i[l*HEAD_W +: 2]),
      .slip_v_o    (slip_v[l]),
      .lock_v_o    (lock_v[l]),
      .lock_nxt_o  (lock_nxt[l])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_all_q <= 1'b0;
    else       lock_all_q <= &lock_nxt;
  end

  assign bus.slip_v_o   = slip_v;
  assign bus.lock_v_o   = lock_v;
  assign bus.lock_all_o = lock_all_q;

endmodule
